alu_share_arbiter: RTL and testbench

//  Shares the single 8-bit ALU (FORWARD/ADD/AND/OR, ZERO flag) between two requesters,
//  e.g. CPU execute stage (port 0) and an address/branch unit (port 1).
//  Per request: arbitrate, latch operands, drive the ALU, wait ALU_WAIT cycles,

---
 rtl/alu_share_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Two-port arbiter that time-shares one external 8-bit ALU: latch the winner's operands, drive the ALU,
// then capture its result and flag. Define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins) instead of round-robin.
module alu_share_arbiter #(
    parameter int WIDTH    = 8,
    parameter int SELW     = 3,
    parameter int ALU_WAIT = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_req0,
    input  logic             i_req1,
    input  logic [WIDTH-1:0] i_opa0,
    input  logic [WIDTH-1:0] i_opb0,
    input  logic [SELW-1:0]  i_sel0,
    input  logic [WIDTH-1:0] i_opa1,
    input  logic [WIDTH-1:0] i_opb1,
    input  logic [SELW-1:0]  i_sel1,
    output logic             o_gnt0,
    output logic             o_gnt1,
    output logic             o_done0,
    output logic             o_done1,
    output logic [WIDTH-1:0] o_res0,
    output logic [WIDTH-1:0] o_res1,
    output logic             o_zero0,
    output logic             o_zero1,
    output logic [WIDTH-1:0] o_alu_data1,
    output logic [WIDTH-1:0] o_alu_data2,
    output logic [SELW-1:0]  o_alu_select,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic             i_alu_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state, w_state;
    logic [3:0]         r_cnt, w_cnt;
    logic               r_win, w_win;
    logic               r_gnt0, w_gnt0, r_gnt1, w_gnt1;
    logic               r_done0, w_done0, r_done1, w_done1;
    logic [WIDTH-1:0]   r_res0, w_res0, r_res1, w_res1;
    logic               r_zero0, w_zero0, r_zero1, w_zero1;
    logic [WIDTH-1:0]   r_d1, w_d1, r_d2, w_d2;
    logic [SELW-1:0]    r_sel, w_sel;
    logic               w_pick;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign w_pick = ~i_req0;
`else
    logic r_last;

    // Pointer holds the port granted last; a contended request goes to the other port.
    assign w_pick = (i_req0 && i_req1) ? ~r_last : i_req1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last <= 1'b1;
        end else if ((r_state == S_IDLE) && (i_req0 || i_req1)) begin
            r_last <= w_pick;
        end
    end
`endif

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_win   = r_win;
        w_gnt0  = 1'b0;
        w_gnt1  = 1'b0;
        w_done0 = 1'b0;
        w_done1 = 1'b0;
        w_res0  = r_res0;
        w_res1  = r_res1;
        w_zero0 = r_zero0;
        w_zero1 = r_zero1;
        w_d1    = r_d1;
        w_d2    = r_d2;
        w_sel   = r_sel;
        case (r_state)
            S_IDLE: begin
                w_d1  = '0;
                w_d2  = '0;
                w_sel = '0;
                if (i_req0 || i_req1) begin
                    w_state = S_EXEC;
                    w_cnt   = 4'(ALU_WAIT);
                    w_win   = w_pick;
                    w_gnt0  = ~w_pick;
                    w_gnt1  = w_pick;
                    w_d1    = w_pick ? i_opa1 : i_opa0;
                    w_d2    = w_pick ? i_opb1 : i_opb0;
                    w_sel   = w_pick ? i_sel1 : i_sel0;
                end else begin
                    w_state = S_IDLE;
                end
            end
            S_EXEC: begin
                w_cnt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state = S_RESP;
                    if (r_win) begin
                        w_res1  = i_alu_result;
                        w_zero1 = i_alu_zero;
                        w_done1 = 1'b1;
                    end else begin
                        w_res0  = i_alu_result;
                        w_zero0 = i_alu_zero;
                        w_done0 = 1'b1;
                    end
                end else begin
                    w_state = S_EXEC;
                end
            end
            S_RESP: begin
                // ALU inputs stay driven through the response cycle, then fall back to FORWARD of 0.
                w_state = S_IDLE;
                w_d1    = '0;
                w_d2    = '0;
                w_sel   = '0;
            end
            default: begin
                w_state = S_IDLE;
                w_d1    = '0;
                w_d2    = '0;
                w_sel   = '0;
            end
        endcase
    end

    // All state and outputs are registered; reset aborts any operation in flight.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_win   <= 1'b0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_res0  <= '0;
            r_res1  <= '0;
            r_zero0 <= 1'b0;
            r_zero1 <= 1'b0;
            r_d1    <= '0;
            r_d2    <= '0;
            r_sel   <= '0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_win   <= w_win;
            r_gnt0  <= w_gnt0;
            r_gnt1  <= w_gnt1;
            r_done0 <= w_done0;
            r_done1 <= w_done1;
            r_res0  <= w_res0;
            r_res1  <= w_res1;
            r_zero0 <= w_zero0;
            r_zero1 <= w_zero1;
            r_d1    <= w_d1;
            r_d2    <= w_d2;
            r_sel   <= w_sel;
        end
    end

    assign o_gnt0       = r_gnt0;
    assign o_gnt1       = r_gnt1;
    assign o_done0      = r_done0;
    assign o_done1      = r_done1;
    assign o_res0       = r_res0;
    assign o_res1       = r_res1;
    assign o_zero0      = r_zero0;
    assign o_zero1      = r_zero1;
    assign o_alu_data1  = r_d1;
    assign o_alu_data2  = r_d2;
    assign o_alu_select = r_sel;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: instance 0 uses ALU_WAIT=1, instance 1 uses ALU_WAIT=3.
// A behavioural ALU sits behind each instance; per-instance monitors pop expected ops on GNT and check them on DONE.
module tb_alu_share_arbiter;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      req0 = 2'b00, req1 = 2'b00;
    logic [1:0][7:0] opa0 = '0, opb0 = '0, opa1 = '0, opb1 = '0;
    logic [1:0][2:0] sel0 = '0, sel1 = '0;
    wire  [1:0]      gnt0, gnt1, done0, done1, zero0, zero1;
    wire  [1:0][7:0] res0, res1, ad1, ad2;
    wire  [1:0][2:0] asel;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         inst;
        int         port;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] sel;
        logic [7:0] res;
        logic       zero;
    } op_t;

    op_t q[$];

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // 000 forwards DATA2; 111 deliberately reports a zero result with ZERO=0.
    function automatic logic [8:0] alu_model(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic       z;
        case (s)
            3'b000:  r = b;
            3'b001:  r = a + b;
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b100:  r = a ^ b;
            default: r = 8'h00;
        endcase
        z = (r == 8'h00) && (s != 3'b111);
        return {z, r};
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int W = (g == 0) ? 1 : 3;
        wire [7:0] alu_r;
        wire       alu_z;
        assign {alu_z, alu_r} = alu_model(asel[g], ad1[g], ad2[g]);

        alu_share_arbiter #(.WIDTH(8), .SELW(3), .ALU_WAIT(W)) u_dut (
            .i_clk        (clk),
            .i_reset      (rst),
            .i_req0       (req0[g]),
            .i_req1       (req1[g]),
            .i_opa0       (opa0[g]),
            .i_opb0       (opb0[g]),
            .i_sel0       (sel0[g]),
            .i_opa1       (opa1[g]),
            .i_opb1       (opb1[g]),
            .i_sel1       (sel1[g]),
            .o_gnt0       (gnt0[g]),
            .o_gnt1       (gnt1[g]),
            .o_done0      (done0[g]),
            .o_done1      (done1[g]),
            .o_res0       (res0[g]),
            .o_res1       (res1[g]),
            .o_zero0      (zero0[g]),
            .o_zero1      (zero1[g]),
            .o_alu_data1  (ad1[g]),
            .o_alu_data2  (ad2[g]),
            .o_alu_select (asel[g]),
            .i_alu_result (alu_r),
            .i_alu_zero   (alu_z)
        );

        op_t        cur;
        logic       busy = 1'b0;
        logic       after_done = 1'b0;
        int         gnt_cyc = 0;
        logic [7:0] h_res0 = 8'h00, h_res1 = 8'h00;
        logic       h_z0 = 1'b0, h_z1 = 1'b0;

        initial forever begin
            @(negedge clk);
            if (gnt0[g] || gnt1[g]) begin
                chk("gnt_expected", 16'(q.size() != 0), 16'd1);
                if (q.size() != 0) begin
                    cur     = q.pop_front();
                    busy    = 1'b1;
                    gnt_cyc = cyc;
                    chk("gnt_inst", 16'(cur.inst), 16'(g));
                    chk("gnt_port", {14'd0, gnt1[g], gnt0[g]}, (cur.port == 1) ? 16'd2 : 16'd1);
                end
            end
            if (busy) begin
                chk("alu_operands", {ad1[g], ad2[g]}, {cur.a, cur.b});
                chk("alu_select", 16'(asel[g]), 16'(cur.sel));
            end
            if (done0[g] || done1[g]) begin
                chk("done_expected", 16'(busy), 16'd1);
                if (busy) begin
                    chk("done_port", {14'd0, done1[g], done0[g]}, (cur.port == 1) ? 16'd2 : 16'd1);
                    chk("latency", 16'(cyc - gnt_cyc), 16'(W));
                    if (cur.port == 1) begin
                        h_res1 = cur.res;
                        h_z1   = cur.zero;
                    end else begin
                        h_res0 = cur.res;
                        h_z0   = cur.zero;
                    end
                    chk("res_zero0", {7'd0, zero0[g], res0[g]}, {7'd0, h_z0, h_res0});
                    chk("res_zero1", {7'd0, zero1[g], res1[g]}, {7'd0, h_z1, h_res1});
                end
                busy       = 1'b0;
                after_done = 1'b1;
            end else if (after_done) begin
                chk("alu_idle", {ad1[g], ad2[g]}, 16'd0);
                chk("alu_idle_sel", 16'(asel[g]), 16'd0);
                after_done = 1'b0;
            end
            if (rst) begin
                busy       = 1'b0;
                after_done = 1'b0;
                h_res0     = 8'h00;
                h_res1     = 8'h00;
                h_z0       = 1'b0;
                h_z1       = 1'b0;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_op(input int inst, input int port, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] s, input logic [7:0] r, input logic z);
        op_t e;
        e = '{inst: inst, port: port, a: a, b: b, sel: s, res: r, zero: z};
        q.push_back(e);
    endtask

    task automatic wait_for(input int inst, input int port, input bit want_done, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 32 && !seen; i++) begin
            tick();
            if (want_done) seen = (port == 1) ? done1[inst] : done0[inst];
            else           seen = (port == 1) ? gnt1[inst] : gnt0[inst];
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s timeout inst=%0d port=%0d", name, inst, port);
        end
    endtask

    task automatic run_op(input int inst, input int port, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] s, input logic [7:0] r, input logic z);
        push_op(inst, port, a, b, s, r, z);
        if (port == 1) begin
            opa1[inst] = a; opb1[inst] = b; sel1[inst] = s; req1[inst] = 1'b1;
        end else begin
            opa0[inst] = a; opb0[inst] = b; sel0[inst] = s; req0[inst] = 1'b1;
        end
        wait_for(inst, port, 1'b0, "gnt_wait");
        if (port == 1) req1[inst] = 1'b0;
        else           req0[inst] = 1'b0;
        wait_for(inst, port, 1'b1, "done_wait");
    endtask

    task automatic chk_all_zero(input int inst, input string tag);
        chk({tag, "_pulses"}, {10'd0, gnt0[inst], gnt1[inst], done0[inst], done1[inst], zero0[inst], zero1[inst]}, 16'd0);
        chk({tag, "_res"}, {res0[inst], res1[inst]}, 16'd0);
        chk({tag, "_alu"}, {ad1[inst], ad2[inst]}, 16'd0);
        chk({tag, "_alu_sel"}, 16'(asel[inst]), 16'd0);
    endtask

    initial begin
        int n;
        int last_port;
        repeat (2) tick();
        chk_all_zero(0, "reset0");
        chk_all_zero(1, "reset1");
        rst = 1'b0;
        tick();

        run_op(0, 0, 8'h05, 8'h03, 3'b001, 8'h08, 1'b0);
        run_op(0, 1, 8'hF0, 8'h0F, 3'b010, 8'h00, 1'b1);
        run_op(0, 0, 8'hFF, 8'h01, 3'b001, 8'h00, 1'b1);
        run_op(0, 0, 8'h11, 8'h5A, 3'b000, 8'h5A, 1'b0);
        run_op(0, 1, 8'hAA, 8'h55, 3'b011, 8'hFF, 1'b0);
        run_op(0, 1, 8'h3C, 8'h3C, 3'b100, 8'h00, 1'b1);
        run_op(0, 0, 8'h12, 8'h34, 3'b111, 8'h00, 1'b0);

        // Contention from a fresh reset, both requests held.
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        opa0[0] = 8'h01; opb0[0] = 8'h02; sel0[0] = 3'b001;
        opa1[0] = 8'h40; opb1[0] = 8'h04; sel1[0] = 3'b011;
        last_port = 0;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            last_port = 0;
`else
            last_port = k % 2;
`endif
            if (last_port == 1) push_op(0, 1, 8'h40, 8'h04, 3'b011, 8'h44, 1'b0);
            else                push_op(0, 0, 8'h01, 8'h02, 3'b001, 8'h03, 1'b0);
        end
        req0[0] = 1'b1;
        req1[0] = 1'b1;
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            tick();
            if (gnt0[0] || gnt1[0]) n++;
        end
        req0[0] = 1'b0;
        req1[0] = 1'b0;
        chk("contention_grants", 16'(n), 16'd4);
        wait_for(0, last_port, 1'b1, "contention_done");

        // Reset mid-operation aborts it; a re-issued request then completes.
        push_op(0, 0, 8'h77, 8'h11, 3'b001, 8'h88, 1'b0);
        opa0[0] = 8'h77; opb0[0] = 8'h11; sel0[0] = 3'b001; req0[0] = 1'b1;
        wait_for(0, 0, 1'b0, "abort_gnt");
        rst = 1'b1;
        req0[0] = 1'b0;
        tick();
        chk_all_zero(0, "abort");
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("abort_no_done", {14'd0, done0[0], done1[0]}, 16'd0);
        run_op(0, 0, 8'h05, 8'h03, 3'b001, 8'h08, 1'b0);

        // Longer settle time on the second instance.
        run_op(1, 0, 8'h0C, 8'h30, 3'b011, 8'h3C, 1'b0);
        run_op(1, 1, 8'h80, 8'h80, 3'b001, 8'h00, 1'b1);

        repeat (4) tick();
        chk("queue_drained", 16'(q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
